// File: rtl/flt2int_seq.sv
// flt2int_seq: multicycle sequencer that reads an IEEE-754 half-precision value
// from data memory and converts it to a saturated 16-bit two's-complement
// integer, truncating toward zero. It then writes the result back to memory.
//
// Ports
//   Clk        rising-edge clock
//   Reset      asynchronous, active-high reset
//   Start      request; a conversion launches once Start is seen high, then low
//   Done       high while the result is valid; held until the next accepted Start
//   mem_addr   data-memory address (read data returns combinationally)
//   mem_rdata  data-memory read data
//   mem_wr_en  data-memory write enable (memory writes on the rising Clk edge)
//   mem_wdata  data-memory write data
//
// Mantissa alignment uses a one-bit-per-cycle shifter, so latency is
// 6+n edges, where n is the shift distance chosen in DECODE.
module flt2int_seq #(
  parameter int AW       = 8,
  parameter int SRC_ADDR = 4,
  parameter int DST_ADDR = 6
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  output logic          Done,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wdata
);

  typedef enum logic [3:0] {
    IDLE, ARMED, RD_LO, RD_HI, DECODE, SHIFT, WR_LO, WR_HI, DONE
  } state_t;

  state_t      state, nxt;
  logic [7:0]  lo_byte, hi_byte;
  logic [15:0] mag;
  logic [3:0]  cnt;
  logic        dir_left, sat, sgn;

  // Decode of the latched operand
  logic [15:0] f;
  logic [4:0]  e;
  logic [10:0] m;
  logic [3:0]  dec_n;
  logic        dec_left;
  logic [15:0] result;

  assign f = {hi_byte, lo_byte};
  assign e = f[14:10];
  assign m = {|e, f[9:0]};

  always_comb begin
    dec_n    = '0;
    dec_left = 1'b0;
    if (e == 5'd0 || e >= 5'd30) begin
      dec_n = '0;
    end else if (e >= 5'd25) begin
      dec_left = 1'b1;
      dec_n    = 4'(e - 5'd25);
    end else if (e <= 5'd13) begin
      // 11-bit mantissa is fully gone after 12 right shifts; cap the distance
      dec_n = 4'd12;
    end else begin
      dec_n = 4'(5'd25 - e);
    end
  end

  // Negating a zero magnitude gives 0, so -0.0 naturally maps to 0x0000
  always_comb begin
    if (sat)      result = sgn ? 16'h8000 : 16'h7FFF;
    else if (sgn) result = 16'(-mag);
    else          result = mag;
  end

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: if (Start) nxt = ARMED;
      ARMED:      if (!Start) nxt = RD_LO;
      RD_LO:      nxt = RD_HI;
      RD_HI:      nxt = DECODE;
      DECODE:     nxt = (dec_n == 4'd0) ? WR_LO : SHIFT;
      // The last shift happens on the edge that leaves SHIFT
      SHIFT:      if (cnt == 4'd1) nxt = WR_LO;
      WR_LO:      nxt = WR_HI;
      WR_HI:      nxt = DONE;
      default:    nxt = IDLE;
    endcase
  end

  // Memory-side outputs
  always_comb begin
    mem_addr  = '0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    case (state)
      RD_LO: mem_addr = AW'(SRC_ADDR);
      RD_HI: mem_addr = AW'(SRC_ADDR + 1);
      WR_LO: begin
        mem_addr  = AW'(DST_ADDR);
        mem_wr_en = 1'b1;
        mem_wdata = result[7:0];
      end
      WR_HI: begin
        mem_addr  = AW'(DST_ADDR + 1);
        mem_wr_en = 1'b1;
        mem_wdata = result[15:8];
      end
      default: ;
    endcase
  end

  // Done is registered and therefore lags entry into DONE by one edge
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                                      Done <= 1'b0;
    else if ((state == IDLE || state == DONE) && Start) Done <= 1'b0;
    else if (state == DONE)                         Done <= 1'b1;
  end

  // Datapath: operand capture, decode and the serial shifter
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lo_byte  <= '0;
      hi_byte  <= '0;
      mag      <= '0;
      cnt      <= '0;
      dir_left <= 1'b0;
      sat      <= 1'b0;
      sgn      <= 1'b0;
    end else begin
      case (state)
        RD_LO: lo_byte <= mem_rdata;
        RD_HI: hi_byte <= mem_rdata;
        DECODE: begin
          mag      <= (e == 5'd0) ? 16'd0 : {5'd0, m};
          cnt      <= dec_n;
          dir_left <= dec_left;
          sat      <= (e >= 5'd30);
          sgn      <= f[15];
        end
        SHIFT: begin
          mag <= dir_left ? (mag << 1) : (mag >> 1);
          cnt <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
